// File: rtl/decode_pkg.sv
// decode_pkg: opcodes, ALU op and immediate encodings, and control/packet types shared by the decode stage
package decode_pkg;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_ARITHI = 7'b0010011;
  localparam logic [6:0] OP_ARITH  = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  typedef enum logic [3:0] {INVL, ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT, SLTU} alu_op_e;
  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_J, IMM_U, IMM_N} imm_type_e;
  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       is_jump;
    logic       is_branch;
    alu_op_e    alu_op;
    logic       as1;
    logic       as2;
    logic [1:0] result_src;
    logic [2:0] funct3;
    logic       is_muldiv;
  } ctrl_t;
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        bp_taken;
    logic [31:0] bp_target;
  } fetch_pkt_t;
  // alt selects SUB for funct3=000 and SRA for funct3=101
  function automatic alu_op_e alu_from_f3(input logic [2:0] f3, input logic alt);
    return f3 == 3'b000 ? (alt ? SUB : ADD) :
           f3 == 3'b001 ? SLL :
           f3 == 3'b010 ? SLT :
           f3 == 3'b011 ? SLTU :
           f3 == 3'b100 ? XOR :
           f3 == 3'b101 ? (alt ? SRA : SRL) :
           f3 == 3'b110 ? OR : AND;
  endfunction
endpackage

// File: rtl/decode_if.sv
// decode_if: fetch-side and execute-side handshake/bus signals of the decode stage
interface decode_if #(parameter int XLEN = 32);
  import decode_pkg::*;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     instr_in;
  logic [XLEN-1:0] pc_in;
  logic            bp_taken_in;
  logic [XLEN-1:0] bp_target_in;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     instr_out;
  logic [XLEN-1:0] pc_out;
  logic [XLEN-1:0] pcplus4_out;
  logic            bp_taken_out;
  logic [XLEN-1:0] bp_target_out;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [4:0]      rd;
  logic [XLEN-1:0] imm_out;
  ctrl_t           ctrl_out;
  logic            illegal;
  modport master (
    output in_valid, instr_in, pc_in, bp_taken_in, bp_target_in, flush, out_ready,
    input  in_ready, out_valid, instr_out, pc_out, pcplus4_out, bp_taken_out, bp_target_out,
           rs1, rs2, rd, imm_out, ctrl_out, illegal
  );
  modport slave (
    input  in_valid, instr_in, pc_in, bp_taken_in, bp_target_in, flush, out_ready,
    output in_ready, out_valid, instr_out, pc_out, pcplus4_out, bp_taken_out, bp_target_out,
           rs1, rs2, rd, imm_out, ctrl_out, illegal
  );
endinterface

// File: rtl/decode_imm_gen.sv
// decode_imm_gen: builds the sign-extended immediate for each RV32 immediate format
module decode_imm_gen
  import decode_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:7]     instr,
  input  imm_type_e       imm_type,
  output logic [XLEN-1:0] imm
);
  logic [31:0] imm32;
  // opcode bits never contribute to an immediate, so only [31:7] is taken
  always_comb begin
    imm32 = imm_type == IMM_I ? {{20{instr[31]}}, instr[31:20]} :
            imm_type == IMM_S ? {{20{instr[31]}}, instr[31:25], instr[11:7]} :
            imm_type == IMM_B ? {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0} :
            imm_type == IMM_J ? {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0} :
            imm_type == IMM_U ? {instr[31:12], 12'b0} : 32'b0;
    imm = XLEN'($signed(imm32));
  end
endmodule

// File: rtl/decode_stage.sv
// decode_stage: fetch-packet queue plus combinational RV32 decode of the head entry (RV32M via DECODE_M_EXT_EN)
module decode_stage
  import decode_pkg::*;
#(
  parameter int          XLEN      = 32,
  parameter int          DEPTH     = 2,
  parameter logic [31:0] NOP_INSTR = 32'h33
) (
  input logic     clk,
  input logic     rst_n,
  decode_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
    logic            bp_taken;
    logic [XLEN-1:0] bp_target;
  } pkt_t;
  pkt_t          mem_q [DEPTH];
  pkt_t          head;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push, pop, bad;
  logic [6:0]    opc, f7;
  logic [2:0]    f3;
  ctrl_t         ctrl;
  imm_type_e     imm_type;
  assign bus.in_ready  = count_q != (AW+1)'(DEPTH);
  assign bus.out_valid = count_q != '0;
  assign push = bus.in_valid && bus.in_ready;
  assign pop  = bus.out_valid && bus.out_ready;
  // pointer/count update; flush discards everything including this cycle's push and pop
  always_comb begin
    wr_ptr_d = bus.flush ? '0 : wr_ptr_q + AW'(push);
    rd_ptr_d = bus.flush ? '0 : rd_ptr_q + AW'(pop);
    count_d  = bus.flush ? '0 : count_q + (AW+1)'(push) - (AW+1)'(pop);
  end
  // queue bookkeeping state, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
  // packet storage needs no reset: empty slots are never presented
  always_ff @(posedge clk) begin
    if (push && !bus.flush) mem_q[wr_ptr_q] <= {bus.instr_in, bus.pc_in, bus.bp_taken_in, bus.bp_target_in};
  end
  assign head = bus.out_valid ? mem_q[rd_ptr_q] : {NOP_INSTR, XLEN'(0), 1'b0, XLEN'(0)};
  assign opc  = head.instr[6:0];
  assign f3   = head.instr[14:12];
  assign f7   = head.instr[31:25];
  // opcode decode into the control bundle, then squash side effects of illegal encodings
  always_comb begin
    ctrl        = '0;
    ctrl.alu_op = INVL;
    ctrl.funct3 = f3;
    imm_type    = IMM_N;
    bad         = 1'b0;
    case (opc)
      OP_ARITH: begin
        ctrl.reg_write = 1'b1;
        if (f7 == 7'b0000001) begin
`ifdef DECODE_M_EXT_EN
          ctrl.is_muldiv = 1'b1;
`else
          bad = 1'b1;
`endif
        end else begin
          ctrl.alu_op = alu_from_f3(f3, f7[5]);
          bad = f7 != 7'b0 && !(f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101));
        end
      end
      OP_ARITHI: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_op    = alu_from_f3(f3, f3 == 3'b101 && f7[5]);
        ctrl.as2       = 1'b1;
        imm_type       = IMM_I;
      end
      OP_LOAD: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_read   = 1'b1;
        ctrl.alu_op     = ADD;
        ctrl.as2        = 1'b1;
        ctrl.result_src = 2'b01;
        imm_type        = IMM_I;
      end
      OP_STORE: begin
        ctrl.mem_write = 1'b1;
        ctrl.alu_op    = ADD;
        ctrl.as2       = 1'b1;
        imm_type       = IMM_S;
      end
      OP_BRANCH: begin
        ctrl.is_branch = 1'b1;
        imm_type       = IMM_B;
      end
      OP_JAL: begin
        ctrl.reg_write  = 1'b1;
        ctrl.is_jump    = 1'b1;
        ctrl.alu_op     = ADD;
        ctrl.as1        = 1'b1;
        ctrl.as2        = 1'b1;
        ctrl.result_src = 2'b10;
        imm_type        = IMM_J;
      end
      OP_JALR: begin
        ctrl.reg_write  = 1'b1;
        ctrl.is_jump    = 1'b1;
        ctrl.alu_op     = ADD;
        ctrl.as2        = 1'b1;
        ctrl.result_src = 2'b10;
        imm_type        = IMM_I;
      end
      OP_LUI, OP_AUIPC: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_op    = ADD;
        ctrl.as1       = opc == OP_AUIPC;
        ctrl.as2       = 1'b1;
        imm_type       = IMM_U;
      end
      OP_FENCE: ;
      default: bad = 1'b1;
    endcase
    if (bad) begin
      ctrl.reg_write = 1'b0;
      ctrl.mem_read  = 1'b0;
      ctrl.mem_write = 1'b0;
      ctrl.is_jump   = 1'b0;
      ctrl.is_branch = 1'b0;
      ctrl.alu_op    = INVL;
    end
  end
  decode_imm_gen #(.XLEN(XLEN)) u_imm (
    .instr    (head.instr[31:7]),
    .imm_type (imm_type),
    .imm      (bus.imm_out)
  );
  assign bus.instr_out     = head.instr;
  assign bus.pc_out        = head.pc;
  assign bus.pcplus4_out   = head.pc + XLEN'(4);
  assign bus.bp_taken_out  = head.bp_taken;
  assign bus.bp_target_out = head.bp_target;
  assign bus.rs1           = opc == OP_LUI ? 5'd0 : head.instr[19:15];
  assign bus.rs2           = head.instr[24:20];
  assign bus.rd            = head.instr[11:7];
  assign bus.ctrl_out      = ctrl;
  assign bus.illegal       = bad;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed checks of queue handshake, flush, reset and instruction decode
module tb_decode_stage;
  import decode_pkg::*;
  logic clk = 1'b0;
  logic rst_n;
  int n_chk = 0;
  int n_pass = 0;
  decode_if #(.XLEN(32)) bus ();
  decode_stage #(.XLEN(32), .DEPTH(2), .NOP_INSTR(32'h33)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic v, input logic [31:0] i, input logic [31:0] p);
    bus.in_valid = v;
    bus.instr_in = i;
    bus.pc_in    = p;
  endtask
  task automatic show(input logic [31:0] i);
    drive(1'b1, i, 32'h400);
    bus.out_ready = 1'b0;
    tick;
    bus.in_valid = 1'b0;
  endtask
  task automatic drain;
    bus.out_ready = 1'b1;
    tick;
    bus.out_ready = 1'b0;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    rst_n = 1'b0;
    drive(1'b1, 32'h00500093, 32'h0);
    bus.bp_taken_in = 1'b0;
    bus.bp_target_in = 32'h0;
    bus.flush = 1'b0;
    bus.out_ready = 1'b0;
    tick;
    tick;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_instr", bus.instr_out, 32'h33);
    chk("rst_illegal", bus.illegal, 0);
    chk("rst_pc", bus.pc_out, 0);
    chk("rst_bp_target", bus.bp_target_out, 0);
    bus.in_valid = 1'b0;
    rst_n = 1'b1;
    tick;
    drive(1'b1, 32'h00500093, 32'h100);
    bus.bp_taken_in = 1'b1;
    bus.bp_target_in = 32'h140;
    bus.out_ready = 1'b1;
    chk("no_bypass", bus.out_valid, 0);
    tick;
    bus.in_valid = 1'b0;
    bus.bp_taken_in = 1'b0;
    chk("addi_valid", bus.out_valid, 1);
    chk("addi_imm", bus.imm_out, 5);
    chk("addi_as2", bus.ctrl_out.as2, 1);
    chk("addi_alu", 32'(bus.ctrl_out.alu_op), 32'(ADD));
    chk("addi_pc4", bus.pcplus4_out, 32'h104);
    chk("addi_rd", bus.rd, 1);
    chk("addi_bp_taken", bus.bp_taken_out, 1);
    chk("addi_bp_target", bus.bp_target_out, 32'h140);
    tick;
    chk("addi_popped", bus.out_valid, 0);
    bus.out_ready = 1'b0;
    drive(1'b1, 32'h00100093, 32'h200);
    tick;
    chk("q_in_ready1", bus.in_ready, 1);
    drive(1'b1, 32'h00200113, 32'h204);
    tick;
    chk("q_full", bus.in_ready, 0);
    chk("q_head_a", bus.instr_out, 32'h00100093);
    drive(1'b1, 32'h00300193, 32'h208);
    tick;
    chk("q_held_full", bus.in_ready, 0);
    chk("q_held_head", bus.pc_out, 32'h200);
    bus.out_ready = 1'b1;
    tick;
    chk("q_head_b", bus.instr_out, 32'h00200113);
    chk("q_pc_b", bus.pc_out, 32'h204);
    chk("q_ready_after_pop", bus.in_ready, 1);
    tick;
    chk("q_head_c", bus.instr_out, 32'h00300193);
    chk("q_pc_c", bus.pc_out, 32'h208);
    chk("q_pushpop_valid", bus.out_valid, 1);
    bus.in_valid = 1'b0;
    tick;
    chk("q_drained", bus.out_valid, 0);
    bus.out_ready = 1'b0;
    drive(1'b1, 32'h00400213, 32'h210);
    tick;
    drive(1'b1, 32'h00500293, 32'h214);
    tick;
    chk("fl_full", bus.in_ready, 0);
    bus.flush = 1'b1;
    drive(1'b1, 32'h00600313, 32'h218);
    bus.out_ready = 1'b1;
    #1;
    chk("fl_old_head", bus.instr_out, 32'h00400213);
    tick;
    bus.flush = 1'b0;
    bus.out_ready = 1'b0;
    chk("fl_empty", bus.out_valid, 0);
    chk("fl_in_ready", bus.in_ready, 1);
    chk("fl_nop", bus.instr_out, 32'h33);
    drive(1'b1, 32'h00700393, 32'h300);
    tick;
    bus.in_valid = 1'b0;
    chk("fl_new_pc", bus.pc_out, 32'h300);
    tick;
    chk("fl_single", bus.in_ready, 1);
    drain;
    chk("fl_drained", bus.out_valid, 0);
    show(32'h123452B7);
    chk("lui_rs1", bus.rs1, 0);
    chk("lui_imm", bus.imm_out, 32'h12345000);
    chk("lui_rsrc", bus.ctrl_out.result_src, 0);
    chk("lui_wr", bus.ctrl_out.reg_write, 1);
    chk("lui_as1", bus.ctrl_out.as1, 0);
    chk("lui_rd", bus.rd, 5);
    drain;
    show(32'hFFC100E7);
    chk("jalr_jump", bus.ctrl_out.is_jump, 1);
    chk("jalr_imm", bus.imm_out, 32'hFFFFFFFC);
    chk("jalr_rsrc", bus.ctrl_out.result_src, 2);
    chk("jalr_rs1", bus.rs1, 2);
    drain;
    show(32'h00208463);
    chk("beq_jump", bus.ctrl_out.is_jump, 0);
    chk("beq_branch", bus.ctrl_out.is_branch, 1);
    chk("beq_imm", bus.imm_out, 8);
    chk("beq_alu", 32'(bus.ctrl_out.alu_op), 32'(INVL));
    drain;
    show(32'h010000EF);
    chk("jal_imm", bus.imm_out, 16);
    chk("jal_as1", bus.ctrl_out.as1, 1);
    chk("jal_jump", bus.ctrl_out.is_jump, 1);
    drain;
    show(32'h0020A423);
    chk("sw_mem_write", bus.ctrl_out.mem_write, 1);
    chk("sw_imm", bus.imm_out, 8);
    chk("sw_wr", bus.ctrl_out.reg_write, 0);
    drain;
    show(32'h402081B3);
    chk("sub_alu", 32'(bus.ctrl_out.alu_op), 32'(SUB));
    chk("sub_illegal", bus.illegal, 0);
    drain;
    show(32'h023100B3);
`ifdef DECODE_M_EXT_EN
    chk("mul_muldiv", bus.ctrl_out.is_muldiv, 1);
    chk("mul_illegal", bus.illegal, 0);
    chk("mul_wr", bus.ctrl_out.reg_write, 1);
`else
    chk("mul_muldiv", bus.ctrl_out.is_muldiv, 0);
    chk("mul_illegal", bus.illegal, 1);
    chk("mul_wr", bus.ctrl_out.reg_write, 0);
`endif
    chk("mul_alu", 32'(bus.ctrl_out.alu_op), 32'(INVL));
    drain;
    show(32'h00000073);
    chk("ecall_illegal", bus.illegal, 1);
    chk("ecall_wr", bus.ctrl_out.reg_write, 0);
    chk("ecall_valid", bus.out_valid, 1);
    drain;
    chk("ecall_delivered", bus.out_valid, 0);
    show(32'h0000000F);
    chk("fence_illegal", bus.illegal, 0);
    chk("fence_wr", bus.ctrl_out.reg_write, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", bus.out_valid, 0);
    chk("arst_pc", bus.pc_out, 0);
    chk("arst_in_ready", bus.in_ready, 1);
    tick;
    rst_n = 1'b1;
    tick;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
